vga_row_scanout: RTL and testbench
==================================

// Module: vga_row_scanout
// PURPOSE
//  Parametrised VGA scan-out engine: timing generator plus row-fetch line buffer.
//  Reads one full display row per line from dual-port VRAM (row-wide read port) during hblank.
//  Shifts the row out as BPP-bit pixels with aligned h_sync/v_sync/de; supports
//  double-buffered frames (bank swap at frame boundary), vertical scaling, underflow detect.
//  Sits between the VRAM read port and the VGA pins; successor to the fixed 640x480 mono GPU.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line;  H_FP 16, H_SYNC 96, H_BP 48  hblank phases (pixels)
//  V_ACTIVE 480  visible lines;            V_FP 10, V_SYNC 2,  V_BP 33  vblank phases (lines)
//  H_POL 0 / V_POL 0  sync polarity: 0 = active-low pulse, 1 = active-high
//  BPP 1         bits per pixel; row width ROW_W = H_ACTIVE*BPP (localparam)
//  V_SHIFT 0     vertical scale: memory line = display line >> V_SHIFT (0,1,2)
//  ADDR_W 10     mem_addr width; MSB = frame bank, [ADDR_W-2:0] = memory line
// PORTS
//  gpu_clk       in   1        pixel clock; all logic on rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  enable        in   1        0 = hold timing at origin, outputs idle
//  swap_req      in   1        pulse: toggle display bank at next frame boundary
//  swap_done     out  1        one-cycle pulse when bank toggles
//  mem_req       out  1        row read request, held until mem_valid
//  mem_addr      out  ADDR_W   {bank, line}, stable while mem_req high
//  mem_valid     in   1        row data valid this cycle (accepted only while mem_req=1)
//  mem_data      in   ROW_W    row data; pixel x at bits [x*BPP +: BPP]
//  h_sync/v_sync out  1        syncs, polarity per H_POL/V_POL
//  de            out  1        active-video flag
//  pixel         out  BPP      pixel value, 0 whenever de=0
//  underflow     out  1        sticky: a line started before its row arrived
//  clr_underflow in   1        clears underflow (set wins if same cycle)
// BEHAVIOUR
//  Reset / enable=0: h_cnt=v_cnt=0, bank=0, swap pending=0, FSM IDLE; mem_req=0, de=0,
//   pixel=0, syncs at inactive level, swap_done=0; underflow cleared by reset only.
//  Counters: h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1, wrap together at (H_TOTAL-1,V_TOTAL-1).
//  Outputs registered: syncs/de/pixel reflect counter state one cycle earlier, mutually aligned.
//  Sync active when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); same form for v_cnt.
//  de = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
//  Fetch FSM IDLE->REQ->READY->IDLE:
//   IDLE->REQ at h_cnt==H_ACTIVE when next line vn (v_cnt+1, wraps to 0) < V_ACTIVE;
//    mem_addr={bank, vn>>V_SHIFT}, mem_req=1 from next cycle.
//   REQ->READY on mem_valid: mem_data captured to back buffer, mem_req drops same edge.
//   READY->IDLE at h_cnt==0 of active line: back buffer copied to shift register.
//   Still in REQ at h_cnt==0 of active line: underflow<=1, mem_req drops, late mem_valid
//    ignored, line outputs pixel=0 with de=1; FSM -> IDLE.
//  Pixel: shift register emits bits [BPP-1:0] then shifts right by BPP each active pixel.
//  Bank swap: swap_req sets pending (extra requests while pending absorbed). At v_cnt==V_TOTAL-1,
//   h_cnt==H_ACTIVE (line-0 fetch point) pending clears, bank toggles, swap_done pulses;
//   line-0 fetch uses new bank. swap_req on that same cycle takes effect there.
//  Async reset mid-fetch: mem_req drops immediately; restart from origin after release.
// TESTING (small params: H 8/2/2/2, V 4/1/1/1, BPP 2, 1-cycle memory)
//  Reset then enable -> h_sync low exactly 2 cycles/line, v_sync low 1 line of 14, de 8 cycles/line.
//  Row n = 16'h1B1B+n -> pixels per line match 2-bit LSB-first slices; pixel=0 in blanking.
//  swap_req mid-frame -> swap_done once at (v=6,h=8); next frame mem_addr MSB=1; second
//   swap_req while pending -> still one toggle.
//  Memory withholds mem_valid for line 2 -> underflow=1, line 2 all zero with de=1, line 3 normal;
//   clr_underflow clears it.
//  V_SHIFT=1 -> lines 0,1 request address 0, lines 2,3 request address 1.
//  rst_n low while mem_req=1 -> mem_req/de drop asynchronously, timing restarts at (0,0).

Source files
------------

// File: rtl/vga_row_scanout.sv
// vga_row_scanout: VGA timing generator with a one-row fetch line buffer.
//
// Each display line is fetched as a single row-wide word from VRAM during the
// horizontal blank before it. The row is then shifted out LSB-first as
// BPP-bit pixels with registered, mutually aligned h_sync/v_sync/de.
// Frames are double-buffered: the display bank flips only at the line-0 fetch
// point, so a frame never mixes banks.
//
// Ports:
//   gpu_clk        pixel clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         0 holds timing at the origin with idle outputs
//   swap_req       pulse: flip display bank at the next frame boundary
//   swap_done      one-cycle pulse when the bank flips
//   mem_req        row read request, held until mem_valid or the line starts
//   mem_addr       {bank, memory line}, stable while mem_req is high
//   mem_valid      row data valid (only accepted while mem_req is high)
//   mem_data       row data, pixel x at [x*BPP +: BPP]
//   h_sync/v_sync  sync outputs, polarity set by H_POL/V_POL
//   de             active-video flag
//   pixel          pixel value, 0 outside active video
//   underflow      sticky: a line began before its row arrived
//   clr_underflow  clears underflow (a same-cycle set wins)
module vga_row_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned BPP      = 1,
    parameter int unsigned V_SHIFT  = 0,
    parameter int unsigned ADDR_W   = 10,
    localparam int unsigned ROW_W   = H_ACTIVE * BPP
) (
    input  logic              gpu_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [ROW_W-1:0]  mem_data,
    output logic              h_sync,
    output logic              v_sync,
    output logic              de,
    output logic [BPP-1:0]    pixel,
    output logic              underflow,
    input  logic              clr_underflow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare count of headroom so the sync-end bound always fits.
    localparam int unsigned HW = $clog2(H_TOTAL + 1);
    localparam int unsigned VW = $clog2(V_TOTAL + 1);
    localparam int unsigned LW = ADDR_W - 1;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StReady
    } fetch_state_e;

    fetch_state_e      state_q, state_d;
    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic              bank_q, bank_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ROW_W-1:0]  back_q, back_d;
    logic [ROW_W-1:0]  shift_q, shift_d;
    logic              h_sync_q, h_sync_d;
    logic              v_sync_q, v_sync_d;
    logic              de_q, de_d;
    logic [BPP-1:0]    pixel_q, pixel_d;
    logic              swap_done_q, swap_done_d;
    logic              underflow_q, underflow_d;

    // Position decode from the current counter state.
    logic          h_wrap, v_wrap;
    logic [VW-1:0] v_next;
    logic          active_line, active, line_start;
    logic          fetch_pt, swap_pt, swap_now;
    logic          h_sync_on, v_sync_on;
    logic          uf_set;
    logic [ROW_W-1:0] src;

    assign h_wrap      = (h_cnt_q == H_LAST);
    assign v_wrap      = (v_cnt_q == V_LAST);
    assign v_next      = v_wrap ? '0 : v_cnt_q + VW'(1);
    assign active_line = (v_cnt_q < V_ACT);
    assign active      = (h_cnt_q < H_ACT) && active_line;
    assign line_start  = (h_cnt_q == '0) && active_line;
    // The row for line v_next is requested as soon as line v_cnt's pixels end.
    assign fetch_pt    = (h_cnt_q == H_ACT) && (v_next < V_ACT);
    // The bank flips exactly at the line-0 fetch point, so line 0 already
    // reads from the new bank.
    assign swap_pt     = v_wrap && (h_cnt_q == H_ACT);
    assign swap_now    = swap_pt && (pend_q || swap_req);
    assign h_sync_on   = (h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI);
    assign v_sync_on   = (v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI);

    // At line start the shifter is bypassed so pixel 0 comes straight from the
    // freshly completed row; a missing row yields an all-zero line.
    always_comb begin
        src = shift_q;
        if (line_start) begin
            src = (state_q == StReady) ? back_q : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        bank_d      = bank_q;
        pend_d      = pend_q;
        addr_d      = addr_q;
        back_d      = back_q;
        shift_d     = shift_q;
        h_sync_d    = ~H_POL;
        v_sync_d    = ~V_POL;
        de_d        = 1'b0;
        pixel_d     = '0;
        swap_done_d = 1'b0;
        uf_set      = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            h_cnt_d = '0;
            v_cnt_d = '0;
            bank_d  = 1'b0;
            pend_d  = 1'b0;
            shift_d = '0;
        end else begin
            // Timing counters.
            h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
            if (h_wrap) begin
                v_cnt_d = v_next;
            end

            // Bank swap; a request on the swap cycle itself is honoured there.
            pend_d      = swap_now ? 1'b0 : (pend_q | swap_req);
            bank_d      = bank_q ^ swap_now;
            swap_done_d = swap_now;

            // Row fetch.
            unique case (state_q)
                StIdle: begin
                    if (fetch_pt) begin
                        state_d = StReq;
                        addr_d  = {bank_d, LW'(v_next >> V_SHIFT)};
                    end
                end
                StReq: begin
                    if (line_start) begin
                        state_d = StIdle;
                        uf_set  = 1'b1;
                    end else if (mem_valid) begin
                        state_d = StReady;
                        back_d  = mem_data;
                    end
                end
                StReady: begin
                    if (line_start) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Registered video outputs for the current counter position.
            h_sync_d = h_sync_on ? H_POL : ~H_POL;
            v_sync_d = v_sync_on ? V_POL : ~V_POL;
            de_d     = active;
            if (active) begin
                pixel_d = src[BPP-1:0];
                shift_d = src >> BPP;
            end
        end

        if (uf_set) begin
            underflow_d = 1'b1;
        end else if (clr_underflow) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            bank_q      <= 1'b0;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            back_q      <= '0;
            shift_q     <= '0;
            h_sync_q    <= ~H_POL;
            v_sync_q    <= ~V_POL;
            de_q        <= 1'b0;
            pixel_q     <= '0;
            swap_done_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            bank_q      <= bank_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            back_q      <= back_d;
            shift_q     <= shift_d;
            h_sync_q    <= h_sync_d;
            v_sync_q    <= v_sync_d;
            de_q        <= de_d;
            pixel_q     <= pixel_d;
            swap_done_q <= swap_done_d;
            underflow_q <= underflow_d;
        end
    end

    // mem_req comes straight from the state register so reset drops it at once.
    assign mem_req   = (state_q == StReq);
    assign mem_addr  = addr_q;
    assign h_sync    = h_sync_q;
    assign v_sync    = v_sync_q;
    assign de        = de_q;
    assign pixel     = pixel_q;
    assign swap_done = swap_done_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_row_scanout.sv
// Bench for vga_row_scanout with small timing (H 8/2/2/2, V 4/1/1/1, BPP 2).
// A line-level model tracks position, bank, fetched rows and underflow.
module tb_vga_row_scanout;

    localparam int HA = 8;
    localparam int HT = 14;
    localparam int VA = 4;
    localparam int VT = 7;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, enable, swap_req, clr_underflow;
    logic zero_in;

    logic        swap_done, mem_req, h_sync, v_sync, de, underflow;
    logic [3:0]  mem_addr;
    logic        mem_valid = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic [1:0]  pixel;

    logic        s_swap_done, s_mem_req, s_h_sync, s_v_sync, s_de, s_underflow;
    logic [3:0]  s_mem_addr;
    logic        s_mem_valid = 1'b0;
    logic [15:0] s_mem_data = 16'h0;
    logic [1:0]  s_pixel;

    vga_row_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .BPP(2), .V_SHIFT(0), .ADDR_W(4)
    ) dut (
        .gpu_clk(clk), .rst_n(rst_n), .enable(enable), .swap_req(swap_req),
        .swap_done(swap_done), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_data(mem_data), .h_sync(h_sync), .v_sync(v_sync),
        .de(de), .pixel(pixel), .underflow(underflow), .clr_underflow(clr_underflow)
    );

    vga_row_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .BPP(2), .V_SHIFT(1), .ADDR_W(4)
    ) dut_s (
        .gpu_clk(clk), .rst_n(rst_n), .enable(enable), .swap_req(zero_in),
        .swap_done(s_swap_done), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
        .mem_valid(s_mem_valid), .mem_data(s_mem_data), .h_sync(s_h_sync),
        .v_sync(s_v_sync), .de(s_de), .pixel(s_pixel), .underflow(s_underflow),
        .clr_underflow(zero_in)
    );

    function automatic logic [15:0] row_val(input logic b, input logic [2:0] ln);
        logic [15:0] r;
        r = 16'h1B1B + {13'd0, ln};
        return b ? ~r : r;
    endfunction

    // Memory: answers lat_d cycles late, or never for a withheld line.
    int         lat_d = 0;
    int         lat_cnt = 0;
    bit         wh_en = 1'b0;
    logic [2:0] wh_line = 3'd0;

    always @(posedge clk) begin
        if (mem_req && !mem_valid && !(wh_en && mem_addr[2:0] == wh_line)) begin
            if (lat_cnt >= lat_d) begin
                mem_valid <= 1'b1;
                mem_data  <= row_val(mem_addr[3], mem_addr[2:0]);
                lat_cnt   <= 0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            mem_valid <= 1'b0;
            mem_data  <= 16'h0;
            lat_cnt   <= 0;
        end
    end

    always @(posedge clk) begin
        s_mem_valid <= s_mem_req && !s_mem_valid;
        s_mem_data  <= row_val(s_mem_addr[3], s_mem_addr[2:0]);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state.
    int          mh, mv;
    bit          bank_m, pend_m, uf_m;
    logic [15:0] line_row [VA];
    bit          late [VA];
    bit          last_fetch;
    int          fr_hs, fr_vs, fr_de, fr_done;

    task automatic model_reset(input bit clr_uf);
        mh = 0; mv = 0; bank_m = 0; pend_m = 0;
        for (int i = 0; i < VA; i++) begin
            line_row[i] = 16'h0;
            late[i] = 0;
        end
        if (clr_uf) uf_m = 0;
    endtask

    // One enabled clock: drive inputs, advance the model, check after the edge.
    task automatic step(input bit sreq, input bit clr);
        int          vn;
        logic [2:0]  vn3;
        logic [15:0] row;
        logic [1:0]  epix;
        logic [3:0]  eaddr, esaddr;
        bit          ede, ehs, evs, sp, now, fetch, ls;

        swap_req = sreq;
        clr_underflow = clr;
        vn  = (mv == VT - 1) ? 0 : mv + 1;
        vn3 = 3'(vn);
        ede = (mh < HA) && (mv < VA);
        ehs = !(mh >= 10 && mh < 12);
        evs = (mv != 5);
        epix = 2'd0;
        if (ede) begin
            row = line_row[mv];
            epix = row[2 * mh +: 2];
        end
        sp  = (mv == VT - 1) && (mh == HA);
        now = sp && (pend_m || sreq);
        if (now) bank_m = ~bank_m;
        pend_m = now ? 1'b0 : (pend_m | sreq);
        fetch = (mh == HA) && (vn < VA);
        eaddr = 4'h0;
        esaddr = 4'h0;
        if (fetch) begin
            late[vn] = wh_en && (vn3 == wh_line);
            line_row[vn] = late[vn] ? 16'h0 : row_val(bank_m, vn3);
            eaddr  = {bank_m, vn3};
            esaddr = {1'b0, vn3 >> 1};
        end
        ls = (mh == 0) && (mv < VA);
        if (ls && late[mv]) begin
            uf_m = 1;
            late[mv] = 0;
        end else if (clr) begin
            uf_m = 0;
        end

        @(posedge clk);
        @(negedge clk);
        swap_req = 1'b0;
        clr_underflow = 1'b0;

        chk("de", 32'(de), 32'(ede));
        chk("h_sync", 32'(h_sync), 32'(ehs));
        chk("v_sync", 32'(v_sync), 32'(evs));
        chk("pixel", 32'(pixel), 32'(epix));
        chk("swap_done", 32'(swap_done), 32'(now));
        chk("underflow", 32'(underflow), 32'(uf_m));
        if (fetch) begin
            chk("mem_req_rise", 32'(mem_req), 32'd1);
            chk("mem_addr", 32'(mem_addr), 32'(eaddr));
            chk("vshift_mem_req", 32'(s_mem_req), 32'd1);
            chk("vshift_mem_addr", 32'(s_mem_addr), 32'(esaddr));
        end
        if (ls) chk("mem_req_line_start", 32'(mem_req), 32'd0);
        last_fetch = fetch;

        fr_hs   += (h_sync == 1'b0) ? 1 : 0;
        fr_vs   += (v_sync == 1'b0) ? 1 : 0;
        fr_de   += de ? 1 : 0;
        fr_done += swap_done ? 1 : 0;

        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
    endtask

    typedef struct {
        int sw0;
        int sw1;
        int wh;
        int lat;
        int clr_at;
        int exp_done;
        bit exp_uf;
    } frame_t;

    task automatic run_frame(input frame_t r);
        lat_d = r.lat;
        wh_en = (r.wh >= 0);
        wh_line = (r.wh >= 0) ? 3'(r.wh) : 3'd0;
        fr_hs = 0; fr_vs = 0; fr_de = 0; fr_done = 0;
        for (int i = 0; i < FRAME; i++) step(i == r.sw0 || i == r.sw1, i == r.clr_at);
        wh_en = 1'b0;
        chk("frame_hsync_low", 32'(fr_hs), 32'd14);
        chk("frame_vsync_low", 32'(fr_vs), 32'd14);
        chk("frame_de_cycles", 32'(fr_de), 32'd32);
        chk("frame_swap_done", 32'(fr_done), 32'(r.exp_done));
        chk("frame_underflow", 32'(underflow), 32'(r.exp_uf));
    endtask

    frame_t tbl [7];
    frame_t rr;

    initial begin
        // {sw0, sw1, withheld line, latency, clr_at, swaps, underflow at end}
        tbl[0] = '{-1, -1, -1, 0, -1, 0, 1'b0};
        tbl[1] = '{40, -1, -1, 1, -1, 1, 1'b0};
        tbl[2] = '{10, 60, -1, 2, -1, 1, 1'b0};
        tbl[3] = '{92, -1, -1, 3, -1, 1, 1'b0};
        tbl[4] = '{-1, -1,  2, 0, -1, 0, 1'b1};
        tbl[5] = '{-1, -1, -1, 1,  5, 0, 1'b0};
        tbl[6] = '{30, 92, -1, 0, -1, 1, 1'b0};

        zero_in = 1'b0;
        swap_req = 1'b0;
        clr_underflow = 1'b0;
        enable = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_h_sync", 32'(h_sync), 32'd1);
        chk("rst_v_sync", 32'(v_sync), 32'd1);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_swap_done", 32'(swap_done), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("disabled_de", 32'(de), 32'd0);
        chk("disabled_mem_req", 32'(mem_req), 32'd0);

        enable = 1'b1;
        model_reset(1'b1);
        for (int i = 0; i < 7; i++) run_frame(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            rr.sw0 = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 92));
            rr.sw1 = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 92));
            rr.wh  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : -1;
            rr.lat = int'($urandom_range(0, 3));
            rr.clr_at = 0;
            rr.exp_done = (rr.sw0 >= 0 || rr.sw1 >= 0) ? 1 : 0;
            rr.exp_uf = (rr.wh >= 0);
            run_frame(rr);
        end

        // enable=0 mid-frame: outputs idle, underflow kept, restart at origin.
        lat_d = 0;
        wh_en = 1'b1;
        wh_line = 3'd1;
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
        wh_en = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("dis_de", 32'(de), 32'd0);
        chk("dis_h_sync", 32'(h_sync), 32'd1);
        chk("dis_v_sync", 32'(v_sync), 32'd1);
        chk("dis_pixel", 32'(pixel), 32'd0);
        chk("dis_mem_req", 32'(mem_req), 32'd0);
        chk("dis_underflow_kept", 32'(underflow), 32'(uf_m));
        repeat (3) @(negedge clk);
        chk("dis_hold_de", 32'(de), 32'd0);
        enable = 1'b1;
        model_reset(1'b0);
        rr = '{-1, -1, -1, 0, 0, 0, 1'b0};
        run_frame(rr);

        // Asynchronous reset while a fetch is outstanding.
        last_fetch = 0;
        lat_d = 3;
        for (int i = 0; i < 20 && !last_fetch; i++) step(1'b0, 1'b0);
        chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_de", 32'(de), 32'd0);
        chk("async_vshift_mem_req", 32'(s_mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(1'b1);
        rr = '{-1, -1, -1, 1, -1, 0, 1'b0};
        run_frame(rr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
